// File: rtl/rv_dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// controller state encoding and a word-address helper.
package rv_dmem_ctrl_pkg;

    // Access size codes follow the RISC-V load/store funct3 encoding.
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        DMC_IDLE       = 2'b00,
        DMC_LOAD_WAIT  = 2'b01,
        DMC_STORE_WAIT = 2'b10,
        DMC_DONE       = 2'b11
    } dmc_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_dmem_ctrl_if.sv
// Data-memory bus between the controller (master) and the memory/fabric (slave).
interface rv_dmem_ctrl_if;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_data_s_o;
    logic [3:0]  dm_data_select_o;
    logic        dm_load_o;
    logic        dm_store_o;
    logic        dm_ack_i;
    logic [31:0] dm_data_i;

    modport master (
        output dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o,
        input  dm_ack_i, dm_data_i
    );

    modport slave (
        input  dm_addr_o, dm_data_s_o, dm_data_select_o, dm_load_o, dm_store_o,
        output dm_ack_i, dm_data_i
    );
endinterface

// File: rtl/rv_dmem_ctrl_lane_align.sv
// Combinational byte-lane steering: size code and low address bits select the
// byte enables, replicate store data across lanes and flag misalignment.
module rv_dmem_ctrl_lane_align
    import rv_dmem_ctrl_pkg::*;
(
    input  logic [2:0]  fun_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] data_o,
    output logic        aligned_o
);

    // Unrecognised size codes are treated as full-word accesses.
    always_comb begin
        sel_o     = 4'b1111;
        data_o    = wdata_i;
        aligned_o = (addr_lo_i == 2'b00);
        case (fun_i)
            LDST_B, LDST_BU: begin
                sel_o     = 4'b0001 << addr_lo_i;
                data_o    = {4{wdata_i[7:0]}};
                aligned_o = 1'b1;
            end
            LDST_H, LDST_HU: begin
                sel_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                data_o    = {2{wdata_i[15:0]}};
                aligned_o = ~addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_dmem_ctrl.sv
// Data-memory access sequencer between execute and writeback: one outstanding
// load/store, held bus strobe, captured load word, done flags held until commit.
module rv_dmem_ctrl
    import rv_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT  = 64,
    parameter int TO_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                w_stall_i,
    input  logic                x_valid_i,
    input  logic                x_load_i,
    input  logic                x_store_i,
    input  logic [2:0]          x_fun_i,
    input  logic [31:0]         x_addr_i,
    input  logic [31:0]         x_wdata_i,
    rv_dmem_ctrl_if.master      dm,
    output logic [31:0]         dm_data_l_o,
    output logic                dm_load_done_o,
    output logic                dm_store_done_o,
    output logic                dm_misaligned_o,
    output logic                dm_bus_error_o
);

    localparam logic [TO_WIDTH-1:0] TO_LIM = TO_WIDTH'(TIMEOUT);

    dmc_state_e          state_q, state_d;
    logic [31:0]         addr_q, addr_d, data_s_q, data_s_d, data_l_q, data_l_d;
    logic [3:0]          sel_q, sel_d;
    logic                load_q, load_d, store_q, store_d;
    logic                load_done_q, load_done_d, store_done_q, store_done_d;
    logic                misal_q, misal_d, bus_err_q, bus_err_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    logic [3:0]  la_sel;
    logic [31:0] la_data;
    logic        la_aligned;

    rv_dmem_ctrl_lane_align u_lane_align (
        .fun_i     (x_fun_i),
        .addr_lo_i (x_addr_i[1:0]),
        .wdata_i   (x_wdata_i),
        .sel_o     (la_sel),
        .data_o    (la_data),
        .aligned_o (la_aligned)
    );

    assign cnt_inc = cnt_q + TO_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_s_d     = data_s_q;
        sel_d        = sel_q;
        data_l_d     = data_l_q;
        load_d       = load_q;
        store_d      = store_q;
        load_done_d  = load_done_q;
        store_done_d = store_done_q;
        cnt_d        = cnt_q;
        misal_d      = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            DMC_IDLE: begin
                // A load wins when execute raises both load and store.
                if (x_valid_i && (x_load_i || x_store_i)) begin
                    if (la_aligned) begin
                        addr_d   = word_addr(x_addr_i);
                        data_s_d = la_data;
                        sel_d    = la_sel;
                        cnt_d    = '0;
                        load_d   = x_load_i;
                        store_d  = ~x_load_i;
                        state_d  = x_load_i ? DMC_LOAD_WAIT : DMC_STORE_WAIT;
                    end else begin
                        misal_d      = 1'b1;
                        data_l_d     = '0;
                        load_done_d  = x_load_i;
                        store_done_d = ~x_load_i;
                        state_d      = DMC_DONE;
                    end
                end
            end
            DMC_LOAD_WAIT, DMC_STORE_WAIT: begin
                if (dm.dm_ack_i) begin
                    if (state_q == DMC_LOAD_WAIT) begin
                        data_l_d    = dm.dm_data_i;
                        load_done_d = 1'b1;
                    end else begin
                        store_done_d = 1'b1;
                    end
                    load_d  = 1'b0;
                    store_d = 1'b0;
                    cnt_d   = '0;
                    state_d = DMC_DONE;
                end else if (TIMEOUT != 0 && cnt_inc == TO_LIM) begin
                    load_done_d  = (state_q == DMC_LOAD_WAIT);
                    store_done_d = (state_q == DMC_STORE_WAIT);
                    data_l_d     = '0;
                    bus_err_d    = 1'b1;
                    load_d       = 1'b0;
                    store_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = DMC_DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_inc;
                end
            end
            DMC_DONE: begin
                if (!w_stall_i) begin
                    load_done_d  = 1'b0;
                    store_done_d = 1'b0;
                    state_d      = DMC_IDLE;
                end
            end
            default: state_d = DMC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= DMC_IDLE;
            addr_q       <= '0;
            data_s_q     <= '0;
            sel_q        <= '0;
            data_l_q     <= '0;
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            misal_q      <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_s_q     <= data_s_d;
            sel_q        <= sel_d;
            data_l_q     <= data_l_d;
            load_q       <= load_d;
            store_q      <= store_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            misal_q      <= misal_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dm.dm_addr_o        = addr_q;
    assign dm.dm_data_s_o      = data_s_q;
    assign dm.dm_data_select_o = sel_q;
    assign dm.dm_load_o        = load_q;
    assign dm.dm_store_o       = store_q;
    assign dm_data_l_o         = data_l_q;
    assign dm_load_done_o      = load_done_q;
    assign dm_store_done_o     = store_done_q;
    assign dm_misaligned_o     = misal_q;
    assign dm_bus_error_o      = bus_err_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Scoreboard bench for rv_dmem_ctrl: stimulus queues hand-computed results,
// a negedge monitor pops them whenever a done flag rises.
module tb_rv_dmem_ctrl;
    import rv_dmem_ctrl_pkg::*;

    typedef struct {
        int          id;
        logic        is_load;
        logic [31:0] data_l;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data_s;
        int          strobes;
        int          misal;
        int          berr;
        int          held;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_stall = 1'b0;
    logic        x_valid = 1'b0, x_load = 1'b0, x_store = 1'b0;
    logic [2:0]  x_fun = 3'b0;
    logic [31:0] x_addr = '0, x_wdata = '0;
    logic [31:0] data_l;
    logic        ld_done, st_done, misal, berr;

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    rv_dmem_ctrl_if dm_if ();

    rv_dmem_ctrl #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .w_stall_i       (w_stall),
        .x_valid_i       (x_valid),
        .x_load_i        (x_load),
        .x_store_i       (x_store),
        .x_fun_i         (x_fun),
        .x_addr_i        (x_addr),
        .x_wdata_i       (x_wdata),
        .dm              (dm_if),
        .dm_data_l_o     (data_l),
        .dm_load_done_o  (ld_done),
        .dm_store_done_o (st_done),
        .dm_misaligned_o (misal),
        .dm_bus_error_o  (berr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    // Monitor: tracks one transaction at a time, checks on done rise and fall.
    logic        prev_strobe = 1'b0, prev_done = 1'b0, active = 1'b0;
    int          n_strobe = 0, n_mis = 0, n_err = 0, n_held = 0;
    logic        bus_load;
    logic [31:0] bus_addr, bus_data;
    logic [3:0]  bus_sel;
    exp_t        cur;

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe = 1'b0; prev_done = 1'b0; active = 1'b0;
            n_strobe = 0; n_mis = 0; n_err = 0; n_held = 0;
        end else begin
            if ((dm_if.dm_load_o || dm_if.dm_store_o) && !prev_strobe) begin
                bus_load = dm_if.dm_load_o;
                bus_addr = dm_if.dm_addr_o;
                bus_sel  = dm_if.dm_data_select_o;
                bus_data = dm_if.dm_data_s_o;
            end
            if (dm_if.dm_load_o || dm_if.dm_store_o) n_strobe++;
            if (misal) n_mis++;
            if (berr) n_err++;
            if ((ld_done || st_done) && !prev_done) begin
                chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    n_held = 0;
                    chk($sformatf("v%0d_load_done", cur.id), 32'(ld_done), 32'(cur.is_load));
                    chk($sformatf("v%0d_store_done", cur.id), 32'(st_done), 32'(!cur.is_load));
                    chk($sformatf("v%0d_data_l", cur.id), data_l, cur.data_l);
                    chk($sformatf("v%0d_strobe_cycles", cur.id), 32'(n_strobe), 32'(cur.strobes));
                    if (cur.strobes > 0) begin
                        chk($sformatf("v%0d_bus_is_load", cur.id), 32'(bus_load), 32'(cur.is_load));
                        chk($sformatf("v%0d_addr", cur.id), bus_addr, cur.addr);
                        chk($sformatf("v%0d_sel", cur.id), 32'(bus_sel), 32'(cur.sel));
                        chk($sformatf("v%0d_data_s", cur.id), bus_data, cur.data_s);
                    end
                end
            end
            if (ld_done || st_done) n_held++;
            if (!(ld_done || st_done) && prev_done && active) begin
                chk($sformatf("v%0d_done_held", cur.id), 32'(n_held), 32'(cur.held));
                chk($sformatf("v%0d_misaligned_pulse", cur.id), 32'(n_mis), 32'(cur.misal));
                chk($sformatf("v%0d_bus_error_pulse", cur.id), 32'(n_err), 32'(cur.berr));
                active = 1'b0;
                n_strobe = 0; n_mis = 0; n_err = 0;
            end
            prev_strobe = dm_if.dm_load_o || dm_if.dm_store_o;
            prev_done   = ld_done || st_done;
        end
    end

    // d: ack index within strobe cycles (0 = first strobe cycle), <0 = never ack.
    task automatic issue(input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ld, input logic st, input int d, input logic [31:0] rdata,
                         input int stall_n, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        x_valid = 1'b1; x_load = ld; x_store = st;
        x_fun = fun; x_addr = addr; x_wdata = wdata;
        w_stall = (stall_n > 0);
        @(posedge clk); #1;
        x_valid = 1'b0; x_load = 1'b0; x_store = 1'b0;
        if (e.strobes > 0 && d >= 0) begin
            repeat (d) begin @(posedge clk); #1; end
            dm_if.dm_ack_i = 1'b1;
            dm_if.dm_data_i = rdata;
            @(posedge clk); #1;
            dm_if.dm_ack_i = 1'b0;
            dm_if.dm_data_i = '0;
        end
        for (int i = 0; i < 20 && !(ld_done || st_done); i++) @(negedge clk);
        chk($sformatf("v%0d_done_seen", e.id), 32'(ld_done || st_done), 32'd1);
        if (stall_n > 0) begin
            repeat (stall_n) @(posedge clk);
            #1 w_stall = 1'b0;
        end
        for (int i = 0; i < 20 && (ld_done || st_done); i++) @(negedge clk);
        chk($sformatf("v%0d_done_cleared", e.id), 32'(ld_done || st_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dm_if.dm_ack_i = 1'b0;
        dm_if.dm_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_strobe", 32'(dm_if.dm_load_o), 32'd0);
        chk("rst_store_strobe", 32'(dm_if.dm_store_o), 32'd0);
        chk("rst_addr", dm_if.dm_addr_o, 32'd0);
        chk("rst_data_s", dm_if.dm_data_s_o, 32'd0);
        chk("rst_sel", 32'(dm_if.dm_data_select_o), 32'd0);
        chk("rst_data_l", data_l, 32'd0);
        chk("rst_done_err", {28'd0, ld_done, st_done, misal, berr}, 32'd0);
        rst = 1'b0;

        //                                        id ld data_l        addr        sel      data_s        strb mis err held
        issue(LDST_L,  32'h100, 32'h0,        1, 0,  3, 32'hDEADBEEF, 0,
              '{1, 1'b1, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        4, 0, 0, 1});
        issue(LDST_B,  32'h203, 32'h5A,       0, 1,  0, 32'h0,        0,
              '{2, 1'b0, 32'hDEADBEEF, 32'h200, 4'b1000, 32'h5A5A5A5A, 1, 0, 0, 1});
        issue(LDST_H,  32'h101, 32'h0,        1, 0,  0, 32'h0,        0,
              '{3, 1'b1, 32'h0,        32'h0,   4'b0000, 32'h0,        0, 1, 0, 1});
        issue(LDST_HU, 32'h102, 32'h0,        1, 0,  1, 32'h12345678, 0,
              '{4, 1'b1, 32'h12345678, 32'h100, 4'b1100, 32'h0,        2, 0, 0, 1});
        issue(LDST_L,  32'h40,  32'h0,        1, 0, -1, 32'h0,        0,
              '{5, 1'b1, 32'h0,        32'h40,  4'b1111, 32'h0,        4, 0, 1, 1});
        issue(LDST_H,  32'hF2,  32'hABCD1234, 0, 1,  2, 32'h0,        5,
              '{6, 1'b0, 32'h0,        32'hF0,  4'b1100, 32'h12341234, 3, 0, 0, 6});
        issue(LDST_L,  32'h3,   32'h11223344, 0, 1,  0, 32'h0,        0,
              '{7, 1'b0, 32'h0,        32'h0,   4'b0000, 32'h0,        0, 1, 0, 1});
        issue(LDST_B,  32'h1,   32'h1C3,      0, 1,  0, 32'h0,        0,
              '{8, 1'b0, 32'h0,        32'h0,   4'b0010, 32'hC3C3C3C3, 1, 0, 0, 1});
        issue(LDST_BU, 32'h3,   32'h0,        1, 1,  0, 32'hCAFEF00D, 0,
              '{9, 1'b1, 32'hCAFEF00D, 32'h0,   4'b1000, 32'h0,        1, 0, 0, 1});
        issue(LDST_L,  32'h10,  32'h55AA55AA, 0, 1, -1, 32'h0,        0,
              '{10, 1'b0, 32'h0,       32'h10,  4'b1111, 32'h55AA55AA, 4, 0, 1, 1});

        // Asynchronous reset in the middle of a load wait, then a stray ack.
        @(posedge clk); #1;
        x_valid = 1'b1; x_load = 1'b1; x_fun = LDST_L; x_addr = 32'h80;
        @(posedge clk); #1;
        x_valid = 1'b0; x_load = 1'b0;
        chk("rst_mid_strobe_before", 32'(dm_if.dm_load_o), 32'd1);
        #3 rst = 1'b1;
        #1 chk("rst_mid_strobe_dropped", 32'(dm_if.dm_load_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dm_if.dm_ack_i = 1'b1;
        dm_if.dm_data_i = 32'h11111111;
        @(posedge clk); #1;
        dm_if.dm_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("late_ack_strobe_%0d", i), 32'(dm_if.dm_load_o || dm_if.dm_store_o), 32'd0);
            chk($sformatf("late_ack_done_%0d", i), 32'(ld_done || st_done), 32'd0);
            chk($sformatf("late_ack_data_l_%0d", i), data_l, 32'd0);
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
